hazard_pattern_decoder: RTL
===========================

Name: hazard_pattern_decoder

Overview:
- Receive-side counterpart of the hazard-lights pattern generator.
- Watches the 3-bit light pattern one sample at a time and recovers which wind mode is being displayed: CALM, right-to-left (RL) or left-to-right (LR).
- Reports lock status and flags illegal patterns or illegal transitions.
- Sits on the fast board clock; in_valid marks the divided-clock ticks on which the lights update.

Parameters:
- LOCK_COUNT, 3: consecutive same-class legal transitions required to declare lock (range 1..15).
- ERRW, 8: width of the optional error counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  pattern sample strobe; all state holds while low
- pattern  input  3  light pattern, bit 2 = leftmost light
- mode  output  2  decoded mode: 00 CALM, 01 RL, 10 LR (11 never driven)
- locked  output  1  high while mode is confirmed
- mode_chg  output  1  one-cycle pulse when lock is (re)acquired on a mode different from the previous mode value
- err  output  1  one-cycle pulse on an illegal pattern or illegal transition

Behaviour:
- Reset (async assert, sync release) sets: state EMPTY, prev=000, cand=CALM, cnt=0, mode=00, locked=0, mode_chg=0, err=0.
- Legal patterns: 101, 010, 001, 100. All others (000, 011, 110, 111) are illegal.
- Transition classes for prev->cur:
  - CALM: 101->010, 010->101.
  - RL: 001->010, 010->100, 100->001.
  - LR: 100->010, 010->001, 001->100.
  - Any other pair of legal patterns, including a repeat, is ILLEGAL_T.
- All outputs are registered. Response appears the cycle after the in_valid sample.
- err and mode_chg are pulses; they are 0 on any cycle without a qualifying event.
- State EMPTY, on in_valid:
  - Legal pattern: prev<=pattern, cnt<=0, go to ACQ.
  - Illegal pattern: err pulse, stay in EMPTY.
- State ACQ, on in_valid:
  - Illegal pattern: err pulse, go to EMPTY, cnt<=0.
  - ILLEGAL_T: err pulse, prev<=pattern, cnt<=0.
  - Class c, and (cnt==0 or c==cand): cand<=c, cnt<=cnt+1.
  - Class c different from cand: cand<=c, cnt<=1.
  - When the updated cnt equals LOCK_COUNT: go to LOCK, locked<=1, mode<=cand. mode_chg pulses if the new mode differs from the old mode.
  - prev<=pattern on every legal pattern.
- State LOCK, on in_valid:
  - Class equals mode: stay in LOCK.
  - Different legal class c: locked<=0, cand<=c, cnt<=1, go to ACQ. mode holds its last value.
  - ILLEGAL_T: err pulse, locked<=0, cnt<=0, go to ACQ.
  - Illegal pattern: err pulse, locked<=0, go to EMPTY.
- LOCK_COUNT=1: lock is declared on the first classified transition.
- cnt saturates at LOCK_COUNT and never wraps.
- mode keeps its last locked value while unlocked. Consumers must gate mode with locked.

Optional Feature:
- Macro: HAZARD_DEC_ERR_COUNT_EN.
- Defined: adds output err_count [ERRW-1:0].
  - Increments on every err pulse.
  - Saturates at 2^ERRW-1 (255 by default).
  - Cleared only by reset.
- Undefined: no port, no counter logic. All other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - mode_t enum: CALM=2'b00, RL=2'b01, LR=2'b10.
  - Pattern constants: P_CALM_A=101, P_CALM_B=010, P_R=001, P_M=010, P_L=100.
  - cls_t enum: CLS_CALM, CLS_RL, CLS_LR, CLS_ILLEGAL.
- The package is also imported by the generator side so both ends share one encoding.
- One combinational sub-module, hazard_transition_classifier: inputs prev and cur, outputs cls_t and pattern_legal.
- The decoder holds the FSM, counter and output registers.

Test Plan:
All scenarios use LOCK_COUNT=3.
- Reset, then valid samples 101,010,101,010 -> after the 4th sample: locked=1, mode=00, mode_chg=0 (mode was already 00), err never pulses.
- Valid samples 001,010,100,001 -> locked=1, mode=01, mode_chg pulses once. Continuing 010,100 keeps locked=1 with no pulses.
- While locked RL (prev=001), sample 100 -> LR transition: locked=0, mode stays 01. Then 010,001 -> locked=1, mode=10, single mode_chg pulse.
- While locked CALM, sample 111 -> err pulses exactly 1 cycle, locked=0, state EMPTY. Next 101,010,101,010 relocks CALM.
- Valid samples 101,010 with in_valid low for 5 cycles, then 101,010 -> outputs frozen during the gap, lock after the final sample. Sample 010 repeated -> err pulse, cnt reset.
- Assert reset mid-ACQ (cnt=2) -> all outputs 0 immediately, without waiting for a clk edge. With HAZARD_DEC_ERR_COUNT_EN, 300 illegal samples -> err_count=255.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared light-pattern and wind-mode encoding for hazard generator and decoder
package hazard_pkg;

  typedef enum logic [1:0] {
    CALM = 2'b00,
    RL   = 2'b01,
    LR   = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    CLS_CALM,
    CLS_RL,
    CLS_LR,
    CLS_ILLEGAL
  } cls_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACQ,
    ST_LOCK
  } state_t;

  localparam logic [2:0] P_CALM_A = 3'b101;
  localparam logic [2:0] P_CALM_B = 3'b010;
  localparam logic [2:0] P_R      = 3'b001;
  localparam logic [2:0] P_M      = 3'b010;
  localparam logic [2:0] P_L      = 3'b100;

  function automatic mode_t cls_to_mode(input cls_t c);
    case (c)
      CLS_RL:  return RL;
      CLS_LR:  return LR;
      default: return CALM;
    endcase
  endfunction

endpackage

// File: rtl/hazard_transition_classifier.sv
// rtl/hazard_transition_classifier.sv - classifies one prev->cur light transition
module hazard_transition_classifier
  import hazard_pkg::*;
(
  input  logic [2:0] prev,
  input  logic [2:0] cur,
  output cls_t       cls,
  output logic       pattern_legal
);

  always_comb begin
    pattern_legal = cur inside {P_CALM_A, P_CALM_B, P_R, P_L};
    cls           = CLS_ILLEGAL;
    if (pattern_legal) begin
      case ({prev, cur})
        {P_CALM_A, P_CALM_B}, {P_CALM_B, P_CALM_A}:  cls = CLS_CALM;
        {P_R, P_M}, {P_M, P_L}, {P_L, P_R}:          cls = CLS_RL;
        {P_L, P_M}, {P_M, P_R}, {P_R, P_L}:          cls = CLS_LR;
        default:                                     cls = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/hazard_pattern_decoder.sv
// rtl/hazard_pattern_decoder.sv - recovers wind mode and lock status from sampled hazard light patterns
// Optional saturating err_count output under HAZARD_DEC_ERR_COUNT_EN.
module hazard_pattern_decoder
  import hazard_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int ERRW       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [2:0]      pattern,
  output logic [1:0]      mode,
  output logic            locked,
  output logic            mode_chg,
  output logic            err
`ifdef HAZARD_DEC_ERR_COUNT_EN
  ,
  output logic [ERRW-1:0] err_count
`endif
);

  localparam logic [3:0] LC = 4'(LOCK_COUNT);

  state_t     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  mode_t      cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  mode_t      mode_q, mode_d;
  logic       locked_q, locked_d;
  logic       mode_chg_q, mode_chg_d;
  logic       err_q, err_d;

  cls_t       cls;
  logic       pattern_legal;
  mode_t      cls_mode;
  logic [3:0] cnt_acq;

  hazard_transition_classifier u_classifier (
    .prev          (prev_q),
    .cur           (pattern),
    .cls           (cls),
    .pattern_legal (pattern_legal)
  );

  assign cls_mode = cls_to_mode(cls);

  // A run continues only for the same class (or from an empty count); saturates at LC.
  always_comb begin
    cnt_acq = 4'd1;
    if (cnt_q == 4'd0 || cls_mode == cand_q) begin
      cnt_acq = (cnt_q >= LC) ? LC : cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    locked_d   = locked_q;
    mode_chg_d = 1'b0;
    err_d      = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_EMPTY: begin
          if (pattern_legal) begin
            prev_d  = pattern;
            cnt_d   = 4'd0;
            state_d = ST_ACQ;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_ACQ: begin
          if (!pattern_legal) begin
            err_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = ST_EMPTY;
          end else begin
            prev_d = pattern;
            if (cls == CLS_ILLEGAL) begin
              err_d = 1'b1;
              cnt_d = 4'd0;
            end else begin
              cand_d = cls_mode;
              cnt_d  = cnt_acq;
              if (cnt_acq == LC) begin
                state_d    = ST_LOCK;
                locked_d   = 1'b1;
                mode_d     = cls_mode;
                mode_chg_d = (cls_mode != mode_q);
              end
            end
          end
        end
        ST_LOCK: begin
          if (!pattern_legal) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = ST_EMPTY;
          end else begin
            prev_d = pattern;
            if (cls == CLS_ILLEGAL) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = ST_ACQ;
            end else if (cls_mode != mode_q) begin
              locked_d = 1'b0;
              cand_d   = cls_mode;
              cnt_d    = 4'd1;
              state_d  = ST_ACQ;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      prev_q     <= 3'b000;
      cand_q     <= CALM;
      cnt_q      <= 4'd0;
      mode_q     <= CALM;
      locked_q   <= 1'b0;
      mode_chg_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      locked_q   <= locked_d;
      mode_chg_q <= mode_chg_d;
      err_q      <= err_d;
    end
  end

  assign mode     = mode_q;
  assign locked   = locked_q;
  assign mode_chg = mode_chg_q;
  assign err      = err_q;

`ifdef HAZARD_DEC_ERR_COUNT_EN
  logic [ERRW-1:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_d && err_count_q != {ERRW{1'b1}}) begin
      err_count_d = err_count_q + ERRW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule
